// File: rtl/apu_mixer_if.sv
// apu_mixer_if: channel inputs and mixed/DAC outputs of the APU mixer.
// The master side (voice generators) drives the per-channel sample, gain and
// mute vectors. The slave side (the mixer) returns the mix sample, its strobe
// and the 1-bit audio output.
interface apu_mixer_if #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 8
);
    logic [CHANNELS*WIDTH-1:0] chan_data;
    logic [CHANNELS*2-1:0]     chan_gain;
    logic [CHANNELS-1:0]       chan_mute;
    logic [OUT_WIDTH-1:0]      mix_data;
    logic                      sample_valid;
    logic                      pwm;

    modport master (
        output chan_data, chan_gain, chan_mute,
        input  mix_data, sample_valid, pwm
    );

    modport slave (
        input  chan_data, chan_gain, chan_mute,
        output mix_data, sample_valid, pwm
    );
endinterface

// File: rtl/apu_mixer.sv
// apu_mixer: time-multiplexed saturating audio mixer with a 1-bit DAC stage.
// One channel is added per clock; the completed frame is clamped to
// OUT_WIDTH bits and presented on mix_data with a one-cycle sample_valid.
// The DAC is a period-aligned PWM by default. Defining the macro
// APU_MIXER_SIGMA_DELTA_EN replaces it with a first-order sigma-delta stage.
module apu_mixer #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    apu_mixer_if.slave  bus
);
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TERM_W = WIDTH + 3;
    localparam int ACC_W  = WIDTH + 3 + $clog2(CHANNELS);
    localparam int CMP_W  = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;

    logic [IDX_W-1:0]     idx;
    logic [ACC_W-1:0]     acc;
    logic [TERM_W-1:0]    term;
    logic [ACC_W-1:0]     sum_next;
    logic [CMP_W-1:0]     sum_ext;
    logic [CMP_W-1:0]     max_ext;
    logic [CMP_W-1:0]     sat_ext;
    logic [OUT_WIDTH-1:0] mix_next;
    logic [OUT_WIDTH-1:0] mix_data;
    logic                 sample_valid;
    logic                 pwm;
    logic                 last_slot;

    assign last_slot = (idx == IDX_W'(CHANNELS - 1));

    // Pick out the active slot's sample and apply its mute and gain shift.
    always_comb begin
        term = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IDX_W'(i)) begin
                if (!bus.chan_mute[i]) begin
                    term = TERM_W'(bus.chan_data[i*WIDTH +: WIDTH]) << bus.chan_gain[2*i +: 2];
                end
            end
        end
    end

    // Running frame sum (slot 0 restarts it) and the clamp to full scale.
    always_comb begin
        sum_next = (idx == '0) ? ACC_W'(term) : (acc + ACC_W'(term));
        sum_ext  = CMP_W'(sum_next);
        max_ext  = CMP_W'({OUT_WIDTH{1'b1}});
        sat_ext  = (sum_ext > max_ext) ? max_ext : sum_ext;
        mix_next = sat_ext[OUT_WIDTH-1:0];
    end

    // Slot counter, accumulator and the registered mix sample with its strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            acc          <= '0;
            mix_data     <= '0;
            sample_valid <= 1'b0;
        end else begin
            acc <= sum_next;
            if (last_slot) begin
                idx          <= '0;
                mix_data     <= mix_next;
                sample_valid <= 1'b1;
            end else begin
                idx          <= idx + 1'b1;
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef APU_MIXER_SIGMA_DELTA_EN
    logic [OUT_WIDTH-1:0] sd_acc;
    logic [OUT_WIDTH:0]   sd_sum;

    assign sd_sum = {1'b0, sd_acc} + {1'b0, mix_data};

    // First-order sigma-delta: the accumulator carry is the output pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_acc <= '0;
            pwm    <= 1'b0;
        end else begin
            sd_acc <= sd_sum[OUT_WIDTH-1:0];
            pwm    <= sd_sum[OUT_WIDTH];
        end
    end
`else
    logic [OUT_WIDTH-1:0] pwm_cnt;
    logic [OUT_WIDTH-1:0] pwm_level;

    // PWM with the level latched only at the period end so pulses never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt   <= '0;
            pwm_level <= '0;
            pwm       <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == {OUT_WIDTH{1'b1}}) begin
                pwm_level <= mix_data;
            end
            pwm <= (pwm_cnt < pwm_level);
        end
    end
`endif

    assign bus.mix_data     = mix_data;
    assign bus.sample_valid = sample_valid;
    assign bus.pwm          = pwm;
endmodule

// File: doc/apu_mixer.md
# apu_mixer

Parametrised, time-multiplexed audio mixer and 1-bit DAC driver for the APU, generalising the fixed four-channel adder and PWM stage. It takes any number of channel samples, each with its own gain shift and mute. It sums one channel per clock into a saturating mix sample. The sample drives a glitch-free PWM or, when configured, a first-order sigma-delta output. It sits between the voice generators (square, triangle, noise, and future channels) and the board audio pin.

## Interface
- CHANNELS, 4, number of input channels (>=1)
- WIDTH, 4, bits per channel sample (unsigned)
- OUT_WIDTH, 8, bits of mix sample and PWM resolution
- clk  input  1  APU clock
- reset  input  1  asynchronous, active-high reset
- chan_data  input  CHANNELS*WIDTH  channel i in bits [WIDTH*i+WIDTH-1 : WIDTH*i]
- chan_gain  input  CHANNELS*2  per-channel left shift 0..3, channel i in bits [2i+1:2i]
- chan_mute  input  CHANNELS  1 = channel contributes 0
- mix_data  output  OUT_WIDTH  saturated mix sample, registered
- sample_valid  output  1  one-cycle pulse when mix_data updates
- pwm  output  1  registered 1-bit audio output

## Operation
- Slot counter `idx` runs 0..CHANNELS-1 and wraps. It advances every clk.
- Term for the current slot is `chan_mute[idx] ? 0 : chan_data[idx] << chan_gain[idx]`, WIDTH+3 bits.
- Accumulator width is WIDTH+3+$clog2(CHANNELS), minimum WIDTH+3. It cannot overflow.
- When idx==0, `acc <= term`. Otherwise `acc <= acc + term`.
- When idx==CHANNELS-1:
  - `mix_data <= min(acc+term, 2^OUT_WIDTH-1)`.
  - `sample_valid <= 1`.
  - Otherwise `sample_valid <= 0`.
- CHANNELS==1: every cycle is the last slot. mix_data updates every clk and sample_valid stays high.
- Inputs are sampled only in their own slot. A change to a channel mid-frame takes effect at that channel's next slot.
- PWM mode (default):
  - OUT_WIDTH-bit `pwm_cnt` increments every clk and wraps.
  - `pwm_level <= mix_data` only when pwm_cnt is all-ones, so the level changes on period boundaries only.
  - `pwm <= (pwm_cnt < pwm_level)`.
  - Duty is pwm_level/2^OUT_WIDTH. Level 0 gives constant low. Full scale gives 2^OUT_WIDTH-1 highs per period.

## Timing
- Reset values: idx=0, acc=0, mix_data=0, sample_valid=0, pwm=0, pwm_cnt=0, pwm_level=0, sigma-delta accumulator=0.
- Reset mid-frame abandons the partial sum. The first frame after release starts at slot 0.
- First cycle after reset release is cycle 0. sample_valid is first high in cycle CHANNELS, then every CHANNELS cycles.
- Latency from a channel's slot to mix_data is CHANNELS-1-idx+1 cycles.
- Latency from mix_data to pwm_level is up to 2^OUT_WIDTH cycles. From pwm_level to the pwm pin it is 1 cycle.
- No handshake: sample_valid is informational, and downstream logic must capture it the same cycle.

## Configuration
- Macro: APU_MIXER_SIGMA_DELTA_EN.
- Defined: the PWM counter and pwm_level are not built.
  - OUT_WIDTH-bit `sd_acc` updates every clk: `{carry, sd_acc} <= sd_acc + mix_data`.
  - `pwm <= carry`.
  - Pulse density is mix_data/2^OUT_WIDTH.
  - mix_data changes take effect on the next clk.
- Undefined: PWM mode as described in Operation.

## Test plan
Benches use CHANNELS=4, WIDTH=4, OUT_WIDTH=8.
- Reset: assert reset mid-frame with all data 15 -> every output is 0 while reset is held. After release, sample_valid is first high in cycle 4 with mix_data=60.
- Sum: data {15,15,15,15}, gain 0, no mute -> mix_data=60 (0x3C), sample_valid every 4th cycle exactly.
- Gain and saturation:
  - data {15,1,0,0}, gains {2,3,0,0} -> mix_data=68.
  - All data 15, all gains 3 -> raw sum 480, mix_data=255.
- Mute and slot sampling:
  - data all 15 with chan_mute=4'b0010 -> mix_data=45.
  - Change channel 0 to 0 during slot 2 -> the current frame still sums 45, the next frame sums 30.
- PWM: mix_data=64 -> exactly 64 high cycles per 256-cycle period.
  - Change to 128 mid-period -> the current period keeps 64 highs, the next period has 128.
  - mix_data=0 -> pwm stays low.
- Sigma-delta (macro defined): mix_data=64 -> exactly 1 high per 4 cycles, measured over 256 cycles. mix_data=255 -> 255 highs in 256 cycles.
